// File: rtl/program_counter_unit_pkg.sv
// program_counter_unit_pkg
//   Shared definitions for the program counter unit: controller state
//   encodings and default geometry (PC width, reset vector, return-stack
//   depth). Imported by the top, its return stack and the bus interface.
//   Ports: none (package).
//   Optional feature macro: PC_CALL_STACK_EN (enables the hardware call/return stack).
package program_counter_unit_pkg;

  localparam int PC_W_DEFAULT         = 17;
  localparam int RESET_VECTOR_DEFAULT = 0;
  localparam int STACK_DEPTH_DEFAULT  = 4;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    PC_ST_RUN    = 2'd0,
    PC_ST_HALTED = 2'd1,
    PC_ST_FAULT  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/program_counter_unit_if.sv
// program_counter_unit_if
//   Groups the control requests going into the program counter unit and the
//   PC/status values coming out of it.
//   Signals:
//     stall, halt, branchTaken, jumpEn, callEn, retEn : request strobes
//     branchOffset : signed PC-relative offset (target = PC+1+offset)
//     jumpTarget   : absolute target for jump and call
//     pc, pcPlus1  : current PC and PC+1 (mod 2^PC_W)
//     halted, stackError : status flags
//   Modports: master (instruction decode side), slave (the PC unit).
//   Optional feature macro: PC_CALL_STACK_EN (affects the PC unit only).
interface program_counter_unit_if
  import program_counter_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
);
  logic            stall;
  logic            halt;
  logic            branchTaken;
  logic [PC_W-1:0] branchOffset;
  logic            jumpEn;
  logic [PC_W-1:0] jumpTarget;
  logic            callEn;
  logic            retEn;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pcPlus1;
  logic            halted;
  logic            stackError;

  modport master (
    output stall, halt, branchTaken, branchOffset, jumpEn, jumpTarget, callEn, retEn,
    input  pc, pcPlus1, halted, stackError
  );

  modport slave (
    input  stall, halt, branchTaken, branchOffset, jumpEn, jumpTarget, callEn, retEn,
    output pc, pcPlus1, halted, stackError
  );
endinterface

// File: rtl/program_counter_unit_return_stack.sv
// pc_return_stack
//   LIFO of return addresses for call/return. Push and pop are ignored when
//   the stack is full/empty respectively; the caller decides what such an
//   attempt means. Reset clears only the pointer, so stale entries are simply
//   unreachable afterwards.
//   Ports:
//     clk_i, rst_i   : clock, synchronous active-high reset
//     push_i, pushData_i : push request and the address to store
//     pop_i          : pop request
//     top_o          : entry on top of the stack (valid when !empty_o)
//     full_o, empty_o: occupancy flags
//   Instantiated by program_counter_unit only when PC_CALL_STACK_EN is defined.
module pc_return_stack
  import program_counter_unit_pkg::*;
#(
  parameter int PC_W        = PC_W_DEFAULT,
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [PC_W-1:0] pushData_i,
  input  logic            pop_i,
  output logic [PC_W-1:0] top_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int PW = $clog2(STACK_DEPTH + 1);

  logic [PC_W-1:0] mem_q [STACK_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   wrIdx, topIdx;

  // ptr_q counts occupied entries, so the top lives one below it.
  assign full_o  = (ptr_q == PW'(STACK_DEPTH));
  assign empty_o = (ptr_q == '0);
  assign wrIdx   = AW'(ptr_q);
  assign topIdx  = AW'(ptr_q - PW'(1));
  assign top_o   = mem_q[topIdx];

  always_comb begin
    ptr_d = ptr_q;
    if (push_i && !full_o) begin
      ptr_d = ptr_q + PW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage carries no reset; entries above the pointer are never read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_i && !full_o) begin
      mem_q[wrIdx] <= pushData_i;
    end
  end
endmodule

// File: rtl/program_counter_unit.sv
// program_counter_unit
//   Program counter of the single-cycle CPU. Holds PC and selects the next PC
//   each cycle among sequential, PC-relative branch, absolute jump, call and
//   return targets. PC feeds instruction memory and operand-select mux input 6;
//   PC+1 is provided for link/write-back.
//   Ports:
//     clk_i  : clock, all state updates on the rising edge
//     rst_i  : synchronous active-high reset (highest priority)
//     pc_if  : program_counter_unit_if.slave carrying requests in, PC/status out
//   Request priority in RUN: halt > stall > ret > call > jump > branch > PC+1.
//   HALTED and FAULT freeze PC and stack until reset.
//   Optional feature macro: PC_CALL_STACK_EN
//     defined   : call pushes PC+1 onto a STACK_DEPTH return stack, ret pops;
//                 overflow/underflow enters FAULT.
//     undefined : call acts as a jump, ret is ignored, stackError is 0.
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter int              PC_W         = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(RESET_VECTOR_DEFAULT),
  parameter int              STACK_DEPTH  = STACK_DEPTH_DEFAULT
) (
  input logic                    clk_i,
  input logic                    rst_i,
  program_counter_unit_if.slave  pc_if
);
  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pcPlus1;

  assign pcPlus1 = pc_q + PC_W'(1);

`ifdef PC_CALL_STACK_EN
  logic            stackPush, stackPop, stackFull, stackEmpty;
  logic [PC_W-1:0] stackTop;

  pc_return_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (stackPush),
    .pushData_i (pcPlus1),
    .pop_i      (stackPop),
    .top_o      (stackTop),
    .full_o     (stackFull),
    .empty_o    (stackEmpty)
  );
`endif

  // Next-PC priority mux and state transitions. Stalls simply keep the
  // defaults, so lower-priority requests in that cycle are dropped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_CALL_STACK_EN
    stackPush = 1'b0;
    stackPop  = 1'b0;
`endif
    if (state_q == PC_ST_RUN) begin
      if (pc_if.halt) begin
        state_d = PC_ST_HALTED;
      end else if (pc_if.stall) begin
        pc_d = pc_q;
`ifdef PC_CALL_STACK_EN
      end else if (pc_if.retEn) begin
        // An underflowing return faults and leaves PC where it is.
        if (stackEmpty) begin
          state_d = PC_ST_FAULT;
        end else begin
          stackPop = 1'b1;
          pc_d     = stackTop;
        end
      end else if (pc_if.callEn) begin
        if (stackFull) begin
          state_d = PC_ST_FAULT;
        end else begin
          stackPush = 1'b1;
          pc_d      = pc_if.jumpTarget;
        end
`else
      end else if (pc_if.callEn) begin
        pc_d = pc_if.jumpTarget;
`endif
      end else if (pc_if.jumpEn) begin
        pc_d = pc_if.jumpTarget;
      end else if (pc_if.branchTaken) begin
        pc_d = pcPlus1 + pc_if.branchOffset;
      end else begin
        pc_d = pcPlus1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PC_ST_RUN;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_if.pc      = pc_q;
  assign pc_if.pcPlus1 = pcPlus1;
  assign pc_if.halted  = (state_q == PC_ST_HALTED);
`ifdef PC_CALL_STACK_EN
  assign pc_if.stackError = (state_q == PC_ST_FAULT);
`else
  assign pc_if.stackError = 1'b0;
`endif
endmodule

// File: tb/tb_program_counter_unit.sv
// tb_program_counter_unit
//   Testbench for program_counter_unit. Directed scenarios plus a randomized
//   run compared against a behavioural model (integer PC, queue as return
//   stack). Honours PC_CALL_STACK_EN in the same way as the design.
module tb_program_counter_unit;
  import program_counter_unit_pkg::*;

  localparam int PW    = 17;
  localparam int M     = 1 << PW;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   nTests;
  int   nFail;

  // Reference model state
  int   mPc;
  bit   mHalted;
  bit   mFault;
  int   mStack[$];

  program_counter_unit_if #(.PC_W(PW)) pcIf ();

  program_counter_unit #(
    .PC_W         (PW),
    .RESET_VECTOR (17'd0),
    .STACK_DEPTH  (DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .pc_if (pcIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wrap(input int x);
    return ((x % M) + M) % M;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void modelStep();
    int off;
    if (rst) begin
      mPc = 0; mHalted = 0; mFault = 0; mStack.delete();
      return;
    end
    if (mHalted || mFault) return;
    if (pcIf.halt) begin mHalted = 1; return; end
    if (pcIf.stall) return;
`ifdef PC_CALL_STACK_EN
    if (pcIf.retEn) begin
      if (mStack.size() == 0) mFault = 1;
      else mPc = mStack.pop_back();
      return;
    end
    if (pcIf.callEn) begin
      if (mStack.size() == DEPTH) mFault = 1;
      else begin
        mStack.push_back(wrap(mPc + 1));
        mPc = int'(pcIf.jumpTarget);
      end
      return;
    end
`else
    if (pcIf.callEn) begin mPc = int'(pcIf.jumpTarget); return; end
`endif
    if (pcIf.jumpEn) begin
      mPc = int'(pcIf.jumpTarget);
    end else if (pcIf.branchTaken) begin
      off = int'(pcIf.branchOffset);
      if (off >= M / 2) off -= M;
      mPc = wrap(mPc + 1 + off);
    end else begin
      mPc = wrap(mPc + 1);
    end
  endfunction

  task automatic applyIdle();
    rst = 1'b0;
    pcIf.stall = 1'b0; pcIf.halt = 1'b0; pcIf.branchTaken = 1'b0;
    pcIf.branchOffset = '0; pcIf.jumpEn = 1'b0; pcIf.jumpTarget = '0;
    pcIf.callEn = 1'b0; pcIf.retEn = 1'b0;
  endtask

  // One clock: model consumes current inputs, then sample 1ns after the edge.
  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic jumpTo(input logic [PW-1:0] t);
    applyIdle(); pcIf.jumpEn = 1'b1; pcIf.jumpTarget = t; tick(); applyIdle();
  endtask

  task automatic test_reset();
    applyIdle(); rst = 1'b1; tick(); tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h0) begin nFail++; $display("[TB] FAIL reset_pc: got %h want 0", pcIf.pc); end
    nTests++; if (pcIf.halted !== 1'b0 || pcIf.stackError !== 1'b0) begin nFail++; $display("[TB] FAIL reset_flags: halted=%b stackError=%b want 0 0", pcIf.halted, pcIf.stackError); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      nTests++; if (pcIf.pc !== PW'(i)) begin nFail++; $display("[TB] FAIL idle_seq: got %h want %h", pcIf.pc, PW'(i)); end
      nTests++; if (pcIf.pcPlus1 !== PW'(i + 1)) begin nFail++; $display("[TB] FAIL idle_plus1: got %h want %h", pcIf.pcPlus1, PW'(i + 1)); end
    end
  endtask

  task automatic test_branch();
    jumpTo(17'h10);
    pcIf.branchTaken = 1'b1; pcIf.branchOffset = 17'h1FFFD; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h0E) begin nFail++; $display("[TB] FAIL branch_back: got %h want 0e", pcIf.pc); end
    pcIf.branchTaken = 1'b1; pcIf.branchOffset = 17'h00005; pcIf.jumpTarget = 17'h1234; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h14) begin nFail++; $display("[TB] FAIL branch_fwd: got %h want 14", pcIf.pc); end
    pcIf.branchTaken = 1'b1; pcIf.jumpEn = 1'b1; pcIf.jumpTarget = 17'h0777; pcIf.branchOffset = 17'h3; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h0777) begin nFail++; $display("[TB] FAIL jump_over_branch: got %h want 0777", pcIf.pc); end
    jumpTo(17'h1FFFF);
    nTests++; if (pcIf.pcPlus1 !== 17'h0) begin nFail++; $display("[TB] FAIL plus1_wrap: got %h want 0", pcIf.pcPlus1); end
    tick();
    nTests++; if (pcIf.pc !== 17'h0) begin nFail++; $display("[TB] FAIL pc_wrap: got %h want 0", pcIf.pc); end
    jumpTo(17'h1FFFE);
    pcIf.branchTaken = 1'b1; pcIf.branchOffset = 17'h00004; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h3) begin nFail++; $display("[TB] FAIL branch_wrap_up: got %h want 3", pcIf.pc); end
    pcIf.branchTaken = 1'b1; pcIf.branchOffset = 17'h1FFF8; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h1FFFC) begin nFail++; $display("[TB] FAIL branch_wrap_down: got %h want 1fffc", pcIf.pc); end
  endtask

  task automatic test_stall();
    jumpTo(17'h5);
    pcIf.stall = 1'b1; pcIf.jumpEn = 1'b1; pcIf.jumpTarget = 17'h40; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h5) begin nFail++; $display("[TB] FAIL stall_hold: got %h want 5", pcIf.pc); end
    pcIf.jumpEn = 1'b1; pcIf.jumpTarget = 17'h40; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h40) begin nFail++; $display("[TB] FAIL jump_after_stall: got %h want 40", pcIf.pc); end
  endtask

  task automatic test_halt();
    jumpTo(17'h7);
    pcIf.halt = 1'b1; pcIf.jumpEn = 1'b1; pcIf.jumpTarget = 17'h99; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h7 || pcIf.halted !== 1'b1) begin nFail++; $display("[TB] FAIL halt_enter: pc=%h halted=%b want 7 1", pcIf.pc, pcIf.halted); end
    for (int i = 0; i < 4; i++) begin
      pcIf.jumpEn = 1'(i & 1); pcIf.branchTaken = 1'b1; pcIf.callEn = 1'(i >> 1);
      pcIf.jumpTarget = PW'($urandom); pcIf.branchOffset = PW'($urandom); tick(); applyIdle();
      nTests++; if (pcIf.pc !== 17'h7 || pcIf.halted !== 1'b1) begin nFail++; $display("[TB] FAIL halt_frozen: pc=%h halted=%b want 7 1", pcIf.pc, pcIf.halted); end
    end
    rst = 1'b1; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h0 || pcIf.halted !== 1'b0) begin nFail++; $display("[TB] FAIL halt_reset: pc=%h halted=%b want 0 0", pcIf.pc, pcIf.halted); end
  endtask

`ifdef PC_CALL_STACK_EN
  task automatic test_call_ret();
    logic [PW-1:0] want [4];
    want[0] = 17'h100; want[1] = 17'h200; want[2] = 17'h101; want[3] = 17'h4;
    rst = 1'b1; tick(); applyIdle();
    jumpTo(17'h3);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin pcIf.callEn = 1'b1; pcIf.jumpTarget = (i == 0) ? 17'h100 : 17'h200; end
      else pcIf.retEn = 1'b1;
      tick(); applyIdle();
      nTests++; if (pcIf.pc !== want[i]) begin nFail++; $display("[TB] FAIL call_ret_%0d: got %h want %h", i, pcIf.pc, want[i]); end
    end
    pcIf.callEn = 1'b1; pcIf.retEn = 1'b1; pcIf.jumpTarget = 17'h555; tick(); applyIdle();
    nTests++; if (pcIf.stackError !== 1'b1 || pcIf.pc !== 17'h4) begin nFail++; $display("[TB] FAIL ret_wins_empty: pc=%h err=%b want 4 1", pcIf.pc, pcIf.stackError); end
  endtask

  task automatic test_stack_fault();
    rst = 1'b1; tick(); applyIdle();
    jumpTo(17'h9);
    pcIf.retEn = 1'b1; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h9 || pcIf.stackError !== 1'b1) begin nFail++; $display("[TB] FAIL underflow: pc=%h err=%b want 9 1", pcIf.pc, pcIf.stackError); end
    pcIf.jumpEn = 1'b1; pcIf.jumpTarget = 17'h77; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h9) begin nFail++; $display("[TB] FAIL fault_frozen: got %h want 9", pcIf.pc); end
    rst = 1'b1; tick(); applyIdle();
    for (int i = 1; i <= 5; i++) begin
      pcIf.callEn = 1'b1; pcIf.jumpTarget = PW'(i * 16'h100); tick(); applyIdle();
      nTests++; if (pcIf.pc !== PW'((i < 5 ? i : 4) * 16'h100) || pcIf.stackError !== (i == 5)) begin
        nFail++; $display("[TB] FAIL overflow_%0d: pc=%h err=%b want %h %b", i, pcIf.pc, pcIf.stackError, PW'((i < 5 ? i : 4) * 16'h100), (i == 5));
      end
    end
    rst = 1'b1; tick(); applyIdle();
    nTests++; if (pcIf.stackError !== 1'b0) begin nFail++; $display("[TB] FAIL fault_reset: err=%b want 0", pcIf.stackError); end
  endtask
`else
  task automatic test_call_no_stack();
    jumpTo(17'h20);
    pcIf.callEn = 1'b1; pcIf.jumpTarget = 17'h321; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h321) begin nFail++; $display("[TB] FAIL call_as_jump: got %h want 321", pcIf.pc); end
    pcIf.retEn = 1'b1; pcIf.branchTaken = 1'b1; pcIf.branchOffset = 17'h2; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h324 || pcIf.stackError !== 1'b0) begin nFail++; $display("[TB] FAIL ret_ignored: pc=%h err=%b want 324 0", pcIf.pc, pcIf.stackError); end
    pcIf.retEn = 1'b1; pcIf.callEn = 1'b1; pcIf.jumpTarget = 17'h1ABCD; tick(); applyIdle();
    nTests++; if (pcIf.pc !== 17'h1ABCD) begin nFail++; $display("[TB] FAIL ret_call_no_stack: got %h want 1abcd", pcIf.pc); end
  endtask
`endif

  task automatic test_random();
    rst = 1'b1; tick(); applyIdle();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      pcIf.halt = ($urandom_range(0, 49) == 0);
      pcIf.stall = ($urandom_range(0, 5) == 0);
      pcIf.retEn = ($urandom_range(0, 5) == 0);
      pcIf.callEn = ($urandom_range(0, 5) == 0);
      pcIf.jumpEn = ($urandom_range(0, 4) == 0);
      pcIf.branchTaken = ($urandom_range(0, 1) == 0);
      pcIf.branchOffset = ($urandom_range(0, 1) == 0) ? PW'($urandom) : PW'($urandom_range(0, 6) - 3);
      pcIf.jumpTarget = ($urandom_range(0, 3) == 0) ? PW'(M - 1 - $urandom_range(0, 3)) : PW'($urandom);
      tick();
      nTests++; if (pcIf.pc !== PW'(mPc)) begin nFail++; $display("[TB] FAIL rand_pc[%0d]: got %h want %h", i, pcIf.pc, PW'(mPc)); end
      nTests++; if (pcIf.pcPlus1 !== PW'(wrap(mPc + 1))) begin nFail++; $display("[TB] FAIL rand_plus1[%0d]: got %h want %h", i, pcIf.pcPlus1, PW'(wrap(mPc + 1))); end
      nTests++; if (pcIf.halted !== mHalted || pcIf.stackError !== mFault) begin nFail++; $display("[TB] FAIL rand_flags[%0d]: halted=%b err=%b want %b %b", i, pcIf.halted, pcIf.stackError, mHalted, mFault); end
    end
    applyIdle();
  endtask

  initial begin
    nTests = 0; nFail = 0;
    mPc = 0; mHalted = 0; mFault = 0;
    applyIdle();
    test_reset();
    test_branch();
    test_stall();
    test_halt();
`ifdef PC_CALL_STACK_EN
    test_call_ret();
    test_stack_fault();
`else
    test_call_no_stack();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
